// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
//  Bundles the command port, the response port and the APB bus of the
//  upstream APB requester into one interface.
//
//  Request side  : req_valid, req_ready, req_write, req_addr, req_wdata
//  Response side : resp_valid, resp_ready, resp_rdata, resp_err
//  APB side      : PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY
//
//  modport master : the bridge's view (drives req_ready, resp_*, APB outputs)
//  modport slave  : the environment's view (command source, response sink, APB slave)

interface apb_master_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//  Upstream APB requester. Takes one read/write command at a time from a
//  valid/ready request port, runs the APB SETUP/ACCESS sequence, waits for
//  PREADY (or gives up after TIMEOUT stalled ACCESS cycles) and hands the
//  result back on a valid/ready response port.
//
//  Parameters
//   ADDR_W  : APB address width
//   DATA_W  : APB data width
//   TIMEOUT : ACCESS cycles with PREADY low before an error response; 0 waits forever
//
//  Ports
//   PCLK    : clock, rising edge
//   PRESETn : synchronous active-low reset
//   bus     : apb_master_bridge_if.master (request, response and APB signals)

module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_bridge_if.master  bus
);

    // With TIMEOUT=0 the counter is never consulted, but it still needs a legal width.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              respValid_q, respValid_d;
    logic [DATA_W-1:0] respRdata_q, respRdata_d;
    logic              respErr_q,   respErr_d;
    logic [CNT_W-1:0]  waitCnt_q,   waitCnt_d;

    logic timeoutHit;

    // The stall counter holds the number of ACCESS cycles already spent with
    // PREADY low, so hitting TIMEOUT-1 while PREADY is still low means this is
    // the TIMEOUT-th stalled cycle.
    assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == TIMEOUT_LAST);

    // Commands are only taken in IDLE, and never while reset is being applied,
    // even on the first reset cycle before the state register has cleared.
    assign bus.req_ready = PRESETn && (state_q == IDLE);

    assign bus.PSEL       = psel_q;
    assign bus.PENABLE    = penable_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PADDR      = paddr_q;
    assign bus.PWDATA     = pwdata_q;
    assign bus.resp_valid = respValid_q;
    assign bus.resp_rdata = respRdata_q;
    assign bus.resp_err   = respErr_q;

    // Next-state logic for the IDLE -> SETUP -> ACCESS -> RESP loop. Every
    // register holds by default, which keeps PADDR/PWRITE/PWDATA stable across
    // the whole transfer and parked afterwards, and keeps resp_* stable in RESP.
    // PREADY is only looked at in ACCESS and takes priority over the timeout.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        respValid_d = respValid_q;
        respRdata_d = respRdata_q;
        respErr_d   = respErr_q;
        waitCnt_d   = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    pwrite_d  = bus.req_write;
                    paddr_d   = bus.req_addr;
                    pwdata_d  = bus.req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                waitCnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    respRdata_d = pwrite_q ? '0 : bus.PRDATA;
                    respErr_d   = 1'b0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    respValid_d = 1'b1;
                    state_d     = RESP;
                end else if (timeoutHit) begin
                    respRdata_d = '0;
                    respErr_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    respValid_d = 1'b1;
                    state_d     = RESP;
                end else if (waitCnt_q != {CNT_W{1'b1}}) begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    respValid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and every output is registered; reset drops any transfer in
    // flight without producing a response.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            respValid_q <= 1'b0;
            respRdata_q <= '0;
            respErr_q   <= 1'b0;
            waitCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            respValid_q <= respValid_d;
            respRdata_q <= respRdata_d;
            respErr_q   <= respErr_d;
            waitCnt_q   <= waitCnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//  Drives apb_master_bridge with directed table vectors, hand-written corner
//  sequences and random commands. A small APB slave lives here: it inserts a
//  programmable number of PREADY-low ACCESS cycles and holds a 256-word memory.
//  Expected responses come from a word-array model of the slave and the
//  transfer timing rules.

module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waitCyc;
        int          respDelay;
        logic        expErr;
        logic [31:0] expRdata;
        int          expAccess;
        int          expLatency;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master_bridge #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rstN),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Bench slave: PREADY rises on the ACCESS cycle whose index equals waitCycles.
    int          waitCycles  = 0;
    int          accessIdx   = 0;
    int          accessTotal = 0;
    int          respCount   = 0;
    bit          slaveWritten [256] = '{default: 1'b0};
    logic [31:0] slaveMem     [256] = '{default: 32'h0};

    // Reference model of slave contents, written only by the stimulus.
    logic [31:0] refMem [256];

    // Protocol monitor state.
    int          protocolErrs = 0;
    logic [7:0]  setupAddrs [$];
    logic        prevPsel    = 1'b0;
    logic        prevPenable = 1'b0;
    logic        prevPwrite  = 1'b0;
    logic [7:0]  prevPaddr   = 8'h0;
    logic [31:0] prevPwdata  = 32'h0;

    function automatic logic [31:0] initPattern(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    assign bus.PREADY = bus.PSEL && bus.PENABLE && (accessIdx == waitCycles);
    assign bus.PRDATA = slaveWritten[bus.PADDR] ? slaveMem[bus.PADDR] : initPattern(bus.PADDR);

    // Slave bookkeeping on the clock edge the bridge also samples.
    always @(posedge clk) begin
        if (bus.PSEL && bus.PENABLE) begin
            accessTotal <= accessTotal + 1;
            accessIdx   <= accessIdx + 1;
            if (bus.PREADY && bus.PWRITE) begin
                slaveMem[bus.PADDR]     <= bus.PWDATA;
                slaveWritten[bus.PADDR] <= 1'b1;
            end
        end else begin
            accessIdx <= 0;
        end
        if (bus.resp_valid && bus.resp_ready) begin
            respCount <= respCount + 1;
        end
    end

    // APB protocol watch, sampled mid-cycle: one-cycle SETUP, ACCESS only after
    // SETUP, idle gap between transfers, stable address/control/data.
    always @(negedge clk) begin
        int errs;
        errs = 0;
        if (rstN) begin
            if (bus.PSEL && !bus.PENABLE && prevPsel) errs++;
            if (bus.PENABLE && !bus.PSEL) errs++;
            if (bus.PENABLE && !prevPsel) errs++;
            if (bus.PSEL && prevPsel &&
                (bus.PADDR != prevPaddr || bus.PWRITE != prevPwrite || bus.PWDATA != prevPwdata)) errs++;
            if (bus.PSEL && !prevPsel) setupAddrs.push_back(bus.PADDR);
        end
        protocolErrs <= protocolErrs + errs;
        prevPsel     <= bus.PSEL;
        prevPenable  <= bus.PENABLE;
        prevPwrite   <= bus.PWRITE;
        prevPaddr    <= bus.PADDR;
        prevPwdata   <= bus.PWDATA;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Expected result of one command from the transfer rules and the word model.
    task automatic predict(input vec_t vin, output vec_t vout);
        vout = vin;
        if (vin.waitCyc < TIMEOUT) begin
            vout.expErr     = 1'b0;
            vout.expRdata   = vin.write ? 32'h0 : refMem[vin.addr];
            vout.expAccess  = vin.waitCyc + 1;
            vout.expLatency = vin.waitCyc + 3;
            if (vin.write) refMem[vin.addr] = vin.wdata;
        end else begin
            vout.expErr     = 1'b1;
            vout.expRdata   = 32'h0;
            vout.expAccess  = TIMEOUT;
            vout.expLatency = TIMEOUT + 2;
        end
    endtask

    // One full command/response exchange, entered and left on a falling edge.
    // Latency counts clock edges from the accept edge (edge 1) to resp_valid.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          guard;
        int          startAccess;
        int          latency;
        int          stableBad;
        logic        lastPsel;
        logic [31:0] heldRdata;
        logic        heldErr;

        bus.req_write  = v.write;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        waitCycles     = v.waitCyc;

        guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput($sformatf("%s req_ready", tag), 32'(bus.req_ready), 32'h1);
        startAccess = accessTotal;

        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        latency = 1;
        checkOutput($sformatf("%s setup sel/en", tag), 32'({bus.PSEL, bus.PENABLE}), 32'h2);
        checkOutput($sformatf("%s setup addr/dir", tag), 32'({bus.PWRITE, bus.PADDR}), 32'({v.write, v.addr}));

        lastPsel = bus.PSEL;
        while (!bus.resp_valid && latency < 200) begin
            lastPsel = bus.PSEL;
            @(negedge clk);
            latency++;
        end
        checkOutput($sformatf("%s latency", tag), 32'(latency), 32'(v.expLatency));
        checkOutput($sformatf("%s psel drop", tag), 32'({lastPsel, bus.PSEL, bus.PENABLE}), 32'h4);
        checkOutput($sformatf("%s resp_err", tag), 32'(bus.resp_err), 32'(v.expErr));
        checkOutput($sformatf("%s resp_rdata", tag), bus.resp_rdata, v.expRdata);
        checkOutput($sformatf("%s access cycles", tag), 32'(accessTotal - startAccess), 32'(v.expAccess));

        heldRdata = bus.resp_rdata;
        heldErr   = bus.resp_err;
        stableBad = 0;
        for (int i = 0; i < v.respDelay; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_rdata !== heldRdata || bus.resp_err !== heldErr || bus.req_ready)
                stableBad++;
        end
        checkOutput($sformatf("%s resp hold", tag), 32'(stableBad), 32'h0);

        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checkOutput($sformatf("%s resp done", tag), 32'({bus.resp_valid, bus.req_ready}), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t table_v [8];
        vec_t v;
        int   guard;
        int   startIdx;
        int   startResp;

        rstN           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 8'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) refMem[i] = initPattern(8'(i));

        //                 wr    addr   wdata         wait  dly  err   rdata         acc lat
        table_v[0] = '{1'b1, 8'h10, 32'h0000_00A5,    1,   0, 1'b0, 32'h0,         2,  4};
        table_v[1] = '{1'b0, 8'h10, 32'h0,            1,   0, 1'b0, 32'h0000_00A5, 2,  4};
        table_v[2] = '{1'b0, 8'h20, 32'h0,         1000,   0, 1'b1, 32'h0,        16, 18};
        table_v[3] = '{1'b0, 8'h10, 32'h0,           15,   0, 1'b0, 32'h0000_00A5,16, 18};
        table_v[4] = '{1'b1, 8'h33, 32'hDEAD_BEEF,    0,   5, 1'b0, 32'h0,         1,  3};
        table_v[5] = '{1'b0, 8'h33, 32'h0,            0,   5, 1'b0, 32'hDEAD_BEEF, 1,  3};
        table_v[6] = '{1'b1, 8'h44, 32'h1234_5678, 1000,   2, 1'b1, 32'h0,        16, 18};
        table_v[7] = '{1'b0, 8'h44, 32'h0,            2,   0, 1'b0, 32'h44BB_1EC3, 3,  5};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset apb", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}), 32'h0);
        checkOutput("reset pwdata", bus.PWDATA, 32'h0);
        checkOutput("reset resp", 32'({bus.resp_valid, bus.resp_err}), 32'h0);
        checkOutput("reset rdata", bus.resp_rdata, 32'h0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'h0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idle req_ready", 32'(bus.req_ready), 32'h1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(table_v[i], $sformatf("vec%0d", i));
            if (table_v[i].write && !table_v[i].expErr) refMem[table_v[i].addr] = table_v[i].wdata;
        end

        // Back-to-back writes with req_valid held high and the response port always ready.
        bus.resp_ready = 1'b1;
        waitCycles     = 0;
        startIdx       = setupAddrs.size();
        startResp      = respCount;
        bus.req_write  = 1'b1;
        bus.req_addr   = 8'hFF;
        bus.req_wdata  = 32'h1111_1111;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_addr  = 8'h00;
        bus.req_wdata = 32'h2222_2222;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        guard = 0;
        while (respCount < startResp + 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("b2b responses", 32'(respCount - startResp), 32'h2);
        checkOutput("b2b setups", 32'(setupAddrs.size() - startIdx), 32'h2);
        if (setupAddrs.size() >= startIdx + 2) begin
            checkOutput("b2b addr order", 32'({setupAddrs[startIdx], setupAddrs[startIdx + 1]}), 32'hFF00);
        end
        refMem[8'hFF] = 32'h1111_1111;
        refMem[8'h00] = 32'h2222_2222;
        predict('{1'b0, 8'hFF, 32'h0, 1, 0, 1'b0, 32'h0, 0, 0}, v);
        applyStimulus(v, "b2b readback ff");
        predict('{1'b0, 8'h00, 32'h0, 0, 1, 1'b0, 32'h0, 0, 0}, v);
        applyStimulus(v, "b2b readback 00");

        // Reset in the middle of a stalled write.
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h55;
        bus.req_wdata = 32'hCAFE_F00D;
        waitCycles    = 1000;
        bus.req_valid = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid access sel/en", 32'({bus.PSEL, bus.PENABLE}), 32'h3);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("abort apb", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR}), 32'h0);
        checkOutput("abort pwdata", bus.PWDATA, 32'h0);
        checkOutput("abort resp", 32'({bus.resp_valid, bus.resp_err, bus.req_ready}), 32'h0);
        checkOutput("abort rdata", bus.resp_rdata, 32'h0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("after abort", 32'({bus.resp_valid, bus.req_ready}), 32'h1);
        predict('{1'b0, 8'h55, 32'h0, 1, 0, 1'b0, 32'h0, 0, 0}, v);
        applyStimulus(v, "post reset read");

        // Random commands against the model.
        for (int n = 0; n < 30; n++) begin
            vec_t r;
            logic [7:0] addrSet [6];
            addrSet = '{8'h10, 8'h33, 8'h44, 8'h80, 8'hFF, 8'h00};
            r.write     = 1'($urandom_range(0, 1));
            r.addr      = ($urandom_range(0, 6) == 6) ? 8'($urandom) : addrSet[$urandom_range(0, 5)];
            r.wdata     = $urandom;
            r.waitCyc   = $urandom_range(0, 20);
            r.respDelay = $urandom_range(0, 3);
            r.expErr    = 1'b0;
            r.expRdata  = 32'h0;
            r.expAccess = 0;
            r.expLatency = 0;
            predict(r, v);
            applyStimulus(v, $sformatf("rand%0d", n));
        end

        @(negedge clk);
        checkOutput("protocol violations", 32'(protocolErrs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
